// File: rtl/muladd_requant.sv
// muladd_requant: picks end-of-period accumulations, rounds/shifts and saturates them to OUT_W bits
module muladd_requant #(
  parameter int DATA_W  = 32,
  parameter int OUT_W   = 16,
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  input  logic [9:0]         iter,
  input  logic [9:0]         period,
  input  logic [5:0]         shift,
  input  logic               sat_en,
  input  logic [DELAY_W-1:0] delay0
);
  localparam logic signed [DATA_W:0] HI = (DATA_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [DATA_W:0] LO = -HI - 1;
  logic act, v1, v2, take, cap, over, under, unused_running;
  logic [DELAY_W-1:0] delay;
  logic [9:0] cnt, it, per_m1;
  logic [DATA_W-1:0] x1;
  logic signed [DATA_W:0] rnd, rs, r2;
  logic [OUT_W-1:0] rq;
  assign unused_running = running;
  // act blocks sampling after reset until the first run
  always_comb begin
    per_m1 = period == '0 ? '0 : period - 10'd1;
    take = act && !run && delay == '0 && !done && iter != '0;
    cap = take && cnt == per_m1;
    rnd = shift == '0 ? '0 : (DATA_W+1)'(1) << (shift - 6'd1);
    rs = ($signed({x1[DATA_W-1], x1}) + rnd) >>> shift;
    over = r2 > HI;
    under = r2 < LO;
    rq = sat_en && over ? HI[OUT_W-1:0] : sat_en && under ? LO[OUT_W-1:0] : r2[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      act <= 1'b0;
      done <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      delay <= '0;
      cnt <= '0;
      it <= '0;
      x1 <= '0;
      r2 <= '0;
      out0 <= '0;
      out1 <= '0;
    end else if (run) begin
      act <= 1'b1;
      delay <= delay0;
      cnt <= '0;
      it <= '0;
      out1 <= '0;
      done <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= cap;
      v2 <= v1;
      r2 <= rs;
      if (cap) x1 <= in0;
      if (act && delay != '0) delay <= delay - DELAY_W'(1);
      if (act && !done && iter == '0) done <= 1'b1;
      if (take) cnt <= cap ? '0 : cnt + 10'd1;
      if (cap) begin
        it <= it + 10'd1;
        if ({1'b0, it} + 11'd1 >= {1'b0, iter}) done <= 1'b1;
      end
      if (v2) begin
        out0 <= DATA_W'($signed(rq));
        if (sat_en && (over || under) && !(&out1)) out1 <= out1 + DATA_W'(1);
      end
    end
  end
endmodule
